// File: rtl/mem_stage.sv
// RV32I MEM stage: req/ack data-memory port, store lane steering, load extension, MEM/WB register.
// Optional define MEM_MISALIGN_TRAP_EN adds a registered misalign_o flag and suppresses misaligned accesses.
module mem_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        RegWrite_i,
  input  logic [1:0]  WriteSrc_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  input  logic [31:0] ALUout_i,
  input  logic [31:0] regOp2_i,
  input  logic [31:0] ImmOp_i,
  input  logic [31:0] pcPlus4_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic [1:0]  WriteSrc_o,
  output logic [31:0] ALUout_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ImmOp_o,
  output logic [31:0] pcPlus4_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_o,
`endif
  output logic [4:0]  rd_o
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        w_store;
  logic        w_mis;
  logic        w_access;
  logic        w_req;
  logic        w_stall;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Load wins when both strobes are set.
  assign w_store = MemWrite_i & ~MemRead_i;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_mis = (MemRead_i | MemWrite_i) &
                 (((funct3_i[1:0] == 2'b01) & ALUout_i[0]) |
                  ((funct3_i[1:0] == 2'b10) & (ALUout_i[1:0] != 2'b00)));
`else
  assign w_mis = 1'b0;
`endif

  assign w_access = en_i & (MemRead_i | MemWrite_i) & ~w_mis;

  always_comb begin
    w_state_d = r_state;
    w_req     = 1'b0;
    w_stall   = 1'b0;
    case (r_state)
      StIdle: begin
        w_req = w_access;
        if (w_access & ~mem_ack_i) begin
          w_stall   = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        w_req   = 1'b1;
        w_stall = ~mem_ack_i;
        if (mem_ack_i) w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  // Gated by reset so the port drops immediately when reset asserts mid-access.
  assign mem_req_o   = w_req & rst_ni;
  assign stall_o     = w_stall & rst_ni;
  assign mem_we_o    = w_store;
  assign mem_addr_o  = {ALUout_i[31:2], 2'b00};
  assign mem_be_o    = w_be;
  assign mem_wdata_o = w_wdata;

  always_comb begin
    w_be    = 4'hF;
    w_wdata = regOp2_i;
    if (w_store) begin
      case (funct3_i[1:0])
        2'b00: begin
          w_be    = 4'b0001 << ALUout_i[1:0];
          w_wdata = {4{regOp2_i[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << {ALUout_i[1], 1'b0};
          w_wdata = {2{regOp2_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ALUout_i[1:0])
      2'b00:   w_byte = mem_rdata_i[7:0];
      2'b01:   w_byte = mem_rdata_i[15:8];
      2'b10:   w_byte = mem_rdata_i[23:16];
      default: w_byte = mem_rdata_i[31:24];
    endcase
    w_half = ALUout_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_i)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      RegWrite_o <= 1'b0;
      WriteSrc_o <= 2'b00;
      ALUout_o   <= 32'h0;
      ReadData_o <= 32'h0;
      ImmOp_o    <= 32'h0;
      pcPlus4_o  <= 32'h0;
      rd_o       <= 5'h0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else if (w_stall) begin
      RegWrite_o <= 1'b0;
      rd_o       <= 5'h0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else if (en_i) begin
      RegWrite_o <= RegWrite_i & ~w_mis;
      WriteSrc_o <= WriteSrc_i;
      ALUout_o   <= ALUout_i;
      ReadData_o <= (MemRead_i & ~w_mis) ? w_ext : 32'h0;
      ImmOp_o    <= ImmOp_i;
      pcPlus4_o  <= pcPlus4_i;
      rd_o       <= rd_i;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= w_mis;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, multi-cycle corner sequences,
// and randomized accesses checked against a byte-lane arithmetic model.
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic        RegWrite_i;
  logic [1:0]  WriteSrc_i;
  logic        MemWrite_i;
  logic        MemRead_i;
  logic [31:0] ALUout_i;
  logic [31:0] regOp2_i;
  logic [31:0] ImmOp_i;
  logic [31:0] pcPlus4_i;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;
  logic        RegWrite_o;
  logic [1:0]  WriteSrc_o;
  logic [31:0] ALUout_o;
  logic [31:0] ReadData_o;
  logic [31:0] ImmOp_o;
  logic [31:0] pcPlus4_o;
  logic [4:0]  rd_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .RegWrite_i(RegWrite_i),
    .WriteSrc_i(WriteSrc_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .ALUout_i(ALUout_i), .regOp2_i(regOp2_i), .ImmOp_i(ImmOp_i), .pcPlus4_i(pcPlus4_i),
    .rd_i(rd_i), .funct3_i(funct3_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .stall_o(stall_o),
    .RegWrite_o(RegWrite_o), .WriteSrc_o(WriteSrc_o), .ALUout_o(ALUout_o),
    .ReadData_o(ReadData_o), .ImmOp_o(ImmOp_o), .pcPlus4_o(pcPlus4_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .rd_o(rd_o)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        mis;
  } vec_t;

  // Pass-through values of the instruction most recently driven.
  logic        x_rw;
  logic [4:0]  x_rd;
  logic [1:0]  x_ws;
  logic [31:0] x_alu, x_imm, x_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2, input logic rw,
                       input logic [4:0] rd);
    MemRead_i  = ld;
    MemWrite_i = st;
    funct3_i   = f3;
    ALUout_i   = a;
    regOp2_i   = rs2;
    RegWrite_i = rw;
    rd_i       = rd;
    WriteSrc_i = 2'($urandom);
    ImmOp_i    = $urandom;
    pcPlus4_i  = $urandom;
    x_rw = rw; x_rd = rd; x_ws = WriteSrc_i; x_alu = a; x_imm = ImmOp_i; x_pc = pcPlus4_i;
  endtask

  task automatic chk_wb(input string nm, input logic rw, input logic [31:0] rdata);
    chk({nm, ".RegWrite"}, 32'(RegWrite_o), 32'(rw));
    chk({nm, ".rd"}, 32'(rd_o), 32'(x_rd));
    chk({nm, ".ReadData"}, ReadData_o, rdata);
    chk({nm, ".ALUout"}, ALUout_o, x_alu);
    chk({nm, ".ImmOp"}, ImmOp_o, x_imm);
    chk({nm, ".pcPlus4"}, pcPlus4_o, x_pc);
    chk({nm, ".WriteSrc"}, 32'(WriteSrc_o), 32'(x_ws));
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // Lane offset of an access: address rounded down to its size within the word.
  function automatic int lane_off(input logic [31:0] a, input int n);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (!st) return 4'hF;
    n = nbytes(f3);
    return 4'(((1 << n) - 1) << lane_off(a, n));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w, t;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) begin
      t = rs2 >> (8 * (i % n));
      w[8*i +: 8] = t[7:0];
    end
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
    longint v;
    int n;
    n = nbytes(f3);
    if (n == 4) return rdata;
    v = longint'(rdata >> (8 * lane_off(a, n))) & ((64'd1 << (8 * n)) - 1);
    if (!f3[2] && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0; funct3_i = 3'b010;
    ALUout_i = 32'h0; regOp2_i = 32'h0; rd_i = 5'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    WriteSrc_i = 2'b00; ImmOp_i = 32'h0; pcPlus4_i = 32'h0;
  endtask

  vec_t vecs[16];

  initial begin
    int stall_cnt, bubble_cnt;
    logic [31:0] saved_alu;

    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,
                 1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,
                 1'b1, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h00800000,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'hFFFFFF80, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h00800000,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'h00000080, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,
                 1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'hFFFF8001, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80017FFF,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'h00007FFF, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'h12345678, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h101, 32'h00005A5A, 32'h0,
                 1'b1, 1'b1, 4'b0011, 32'h5A5A5A5A, 32'h0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'h0000007F, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 32'hCAFEF00D,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h108, 32'hFFFFFFFF, 32'h0BADF00D,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'b000, 32'h10C, 32'h11111111, 32'h22222222,
                 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h100, 32'h000000C3, 32'h0,
                 1'b1, 1'b1, 4'b0001, 32'hC3C3C3C3, 32'h0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h00008000,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'hFFFF8000, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 3'b011, 32'h10C, 32'h0, 32'h87654321,
                 1'b1, 1'b0, 4'hF, 32'h0, 32'h87654321, 1'b0};

    // Reset state, with a load presented so the request gating is exercised.
    idle_inputs();
    en_i = 1'b1;
    rst_ni = 1'b0;
    MemRead_i = 1'b1;
    #2;
    chk("reset.req", 32'(mem_req_o), 32'h0);
    chk("reset.stall", 32'(stall_o), 32'h0);
    chk("reset.RegWrite", 32'(RegWrite_o), 32'h0);
    chk("reset.ReadData", ReadData_o, 32'h0);
    chk("reset.pcPlus4", pcPlus4_o, 32'h0);
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Zero-wait directed vectors.
    for (int i = 0; i < 16; i++) begin
`ifdef MEM_MISALIGN_TRAP_EN
      if (vecs[i].mis) continue;
`endif
      @(negedge clk_i);
      drive(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].rs2,
            vecs[i].ld | ~(vecs[i].ld | vecs[i].st), 5'(i + 1));
      mem_ack_i = 1'b1;
      mem_rdata_i = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d.req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
      chk($sformatf("vec%0d.stall", i), 32'(stall_o), 32'h0);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d.we", i), 32'(mem_we_o), 32'(vecs[i].e_we));
        chk($sformatf("vec%0d.be", i), 32'(mem_be_o), 32'(vecs[i].e_be));
        chk($sformatf("vec%0d.addr", i), mem_addr_o, vecs[i].addr & 32'hFFFFFFFC);
      end
      if (vecs[i].e_we) chk($sformatf("vec%0d.wdata", i), mem_wdata_o, vecs[i].e_wdata);
      @(posedge clk_i);
      #1;
      chk_wb($sformatf("vec%0d", i), x_rw, vecs[i].e_rdata);
    end

    // LW with the ack arriving after three wait cycles.
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 5'd9);
    stall_cnt = 0;
    bubble_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk_i);
      mem_ack_i = (c == 3);
      mem_rdata_i = (c == 3) ? 32'h5EED1234 : $urandom;
      #1;
      if (stall_o) stall_cnt++;
      @(posedge clk_i);
      #1;
      if (c == 3) break;
      if (!RegWrite_o && rd_o == 5'd0) bubble_cnt++;
    end
    chk("lw_wait.stall_cycles", 32'(stall_cnt), 32'd3);
    chk("lw_wait.bubbles", 32'(bubble_cnt), 32'd3);
    chk_wb("lw_wait", 1'b1, 32'h5EED1234);
    @(negedge clk_i);
    idle_inputs();
    @(posedge clk_i);
    #1;
    chk("lw_wait.single_write", 32'(RegWrite_o), 32'h0);

    // en_i low: no request and MEM/WB frozen.
    @(negedge clk_i);
    drive(1'b0, 1'b0, 3'b010, 32'h44, 32'h0, 1'b1, 5'd5);
    @(posedge clk_i);
    @(negedge clk_i);
    saved_alu = x_alu;
    en_i = 1'b0;
    MemRead_i = 1'b1; ALUout_i = 32'h300; rd_i = 5'd7; RegWrite_i = 1'b1;
    #1;
    chk("en_low.req", 32'(mem_req_o), 32'h0);
    @(posedge clk_i);
    #1;
    chk("en_low.rd_held", 32'(rd_o), 32'd5);
    chk("en_low.alu_held", ALUout_o, saved_alu);
    @(negedge clk_i);
    en_i = 1'b1;
    idle_inputs();

    // Reset asserted while waiting for an ack.
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b1, 5'd3);
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_wait.req_before", 32'(mem_req_o), 32'h1);
    chk("rst_wait.stall_before", 32'(stall_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rst_wait.req", 32'(mem_req_o), 32'h0);
    chk("rst_wait.stall", 32'(stall_o), 32'h0);
    chk("rst_wait.RegWrite", 32'(RegWrite_o), 32'h0);
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_wait.idle_req", 32'(mem_req_o), 32'h0);
    @(posedge clk_i);
    #1;
    chk("rst_wait.idle_stall", 32'(stall_o), 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk_i);
    drive(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 5'd4);
    mem_ack_i = 1'b1;
    #1;
    chk("mis.req", 32'(mem_req_o), 32'h0);
    chk("mis.stall", 32'(stall_o), 32'h0);
    @(posedge clk_i);
    #1;
    chk("mis.flag", 32'(misalign_o), 32'h1);
    chk("mis.RegWrite", 32'(RegWrite_o), 32'h0);
    @(negedge clk_i);
    idle_inputs();
`endif

    // Randomized accesses with random ack latency and occasional enable gaps.
    for (int t = 0; t < 200; t++) begin
      int unsigned kind, d;
      logic ld, st, rw;
      logic [2:0] f3;
      logic [31:0] a, rs2, rdat;
      logic [2:0] lf3[5];
      lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      kind = $urandom_range(0, 3);
      ld = (kind == 0) || (kind == 3);
      st = (kind == 1);
      f3 = ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      a = a / nbytes(f3) * nbytes(f3);
`endif
      rs2 = $urandom;
      rdat = $urandom;
      rw = ld | (kind == 2);
      d = (ld | st) ? $urandom_range(0, 3) : 0;
      @(negedge clk_i);
      en_i = 1'b1;
      drive(ld, st, f3, a, rs2, rw, 5'($urandom));
      for (int unsigned k = 0; k <= d; k++) begin
        if (k > 0) @(negedge clk_i);
        mem_ack_i = (k == d);
        mem_rdata_i = (k == d) ? rdat : $urandom;
        #1;
        chk($sformatf("rnd%0d.req", t), 32'(mem_req_o), 32'(ld | st));
        chk($sformatf("rnd%0d.stall", t), 32'(stall_o), 32'(k != d));
        if (ld | st) begin
          chk($sformatf("rnd%0d.be", t), 32'(mem_be_o), 32'(m_be(st, f3, a)));
          chk($sformatf("rnd%0d.we", t), 32'(mem_we_o), 32'(st));
        end
        if (st) chk($sformatf("rnd%0d.wdata", t), mem_wdata_o, m_wdata(f3, rs2));
        @(posedge clk_i);
        #1;
        if (k != d) chk($sformatf("rnd%0d.bubble", t), 32'({RegWrite_o, rd_o}), 32'h0);
      end
      chk_wb($sformatf("rnd%0d", t), rw, ld ? m_load(f3, a, rdat) : 32'h0);
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk_i);
        en_i = 1'b0;
        MemRead_i = 1'b1;
        rd_i = 5'($urandom);
        mem_ack_i = 1'b0;
        #1;
        chk($sformatf("rnd%0d.gap_req", t), 32'(mem_req_o), 32'h0);
        @(posedge clk_i);
        #1;
        chk($sformatf("rnd%0d.gap_rd", t), 32'(rd_o), 32'(x_rd));
        chk($sformatf("rnd%0d.gap_rw", t), 32'(RegWrite_o), 32'(x_rw));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
